// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the LEGv8 ID->EX ALU issue path.
// Combinational content only; no latency.
// No handshake; imported by the issue stage, its decoder and the hazard unit.
package alu_issue_pkg;

  // ALU operation codes seen by EX
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;
  localparam logic [3:0] ALU_NOR   = 4'd12;

  // Control-unit ALUOp encodings
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CBZ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // R-type opcodes, instruction[31:21]
  localparam logic [10:0] OP_R_ADD = 11'b10001011000;
  localparam logic [10:0] OP_R_SUB = 11'b11001011000;
  localparam logic [10:0] OP_R_AND = 11'b10001010000;
  localparam logic [10:0] OP_R_ORR = 11'b10101010000;
  localparam logic [10:0] OP_R_NOR = 11'b11101010000;

  // I-type opcodes, instruction[31:22]
  localparam logic [9:0] OP_I_ADD = 10'b1001000100;
  localparam logic [9:0] OP_I_SUB = 10'b1101000100;
  localparam logic [9:0] OP_I_AND = 10'b1001001000;
  localparam logic [9:0] OP_I_OR  = 10'b1011001000;

  localparam int DATA_W_DEF = 64;
  localparam int REG_W_DEF  = 5;

  // One issued instruction at the default datapath widths
  typedef struct packed {
    logic [3:0]            op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [REG_W_DEF-1:0]  rd;
    logic                  illegal;
  } entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// EX-side ALU issue bus: one instruction per valid/ready transfer.
// Wires only; no latency.
// Producer holds all payload fields stable while out_valid & !out_ready.
interface alu_issue_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        alu_operation;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [REG_W-1:0]  rd_out;
  logic              illegal;

  modport master (
    output out_valid, alu_operation, operand_a, operand_b, rd_out, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, alu_operation, operand_a, operand_b, rd_out, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_op_decode.sv
// ALUOp + opcode -> 4-bit ALU code, flagging undecodable opcodes.
// Purely combinational, zero latency.
// No handshake; also instantiated by the hazard unit.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  code,
  output logic        illegal
);

  // Unknown R/I opcodes fall back to code 0 and raise illegal
  always_comb begin
    code    = ALU_AND;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: code = ALU_ADD;
      ALUOP_CBZ: code = ALU_PASSB;
      ALUOP_R: begin
        case (opcode)
          OP_R_ADD: code = ALU_ADD;
          OP_R_SUB: code = ALU_SUB;
          OP_R_AND: code = ALU_AND;
          OP_R_ORR: code = ALU_OR;
          OP_R_NOR: code = ALU_NOR;
          default:  illegal = 1'b1;
        endcase
      end
      default: begin
        case (opcode[10:1])
          OP_I_ADD: code = ALU_ADD;
          OP_I_SUB: code = ALU_SUB;
          OP_I_AND: code = ALU_AND;
          OP_I_OR:  code = ALU_OR;
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decode ALU op, mux operand B, hold in a main+skid pair.
// Latency 1 cycle into an empty/draining output slot; 1 transfer/cycle sustained.
// in_ready is a flop (skid empty), so EX out_ready never reaches decode combinationally.
// Optional ALU_ISSUE_PERF_EN adds saturating stall_cycles / issued_count counters.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [10:0]        opcode,
  input  logic               alu_src,
  input  logic [DATA_W-1:0]  read_data1,
  input  logic [DATA_W-1:0]  read_data2,
  input  logic [DATA_W-1:0]  imm,
  input  logic [REG_W-1:0]   rd_in,
  alu_issue_stage_if.master  ex
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        issued_count
`endif
);

  // Same layout as alu_issue_pkg::entry_t, sized by this instance's parameters
  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  rd;
    logic              illegal;
  } slot_t;

  logic       dec_illegal;
  logic [3:0] dec_code;
  slot_t      in_entry;
  slot_t      main_q;
  slot_t      skid_q;
  logic       main_vld;
  logic       skid_vld;
  logic       in_fire;
  logic       main_free;

  alu_op_decode u_decode (
    .alu_op  (alu_op),
    .opcode  (opcode),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // Decode and B-mux ahead of the register so EX sees final operands
  always_comb begin
    in_entry.op      = dec_code;
    in_entry.a       = read_data1;
    in_entry.b       = alu_src ? imm : read_data2;
    in_entry.rd      = rd_in;
    in_entry.illegal = dec_illegal;
  end

  // The skid only ever holds data while the main slot is stalled
  assign in_ready  = ~skid_vld;
  assign in_fire   = in_valid & in_ready;
  assign main_free = ~main_vld | ex.out_ready;

  // Main slot refills from skid first (FIFO order), else straight from input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= in_fire;
        if (in_fire) main_q <= in_entry;
      end
    end else if (in_fire) begin
      skid_q   <= in_entry;
      skid_vld <= 1'b1;
    end
  end

  assign ex.out_valid     = main_vld;
  assign ex.alu_operation = main_q.op;
  assign ex.operand_a     = main_q.a;
  assign ex.operand_b     = main_q.b;
  assign ex.rd_out        = main_q.rd;
  assign ex.illegal       = main_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
  // Saturating stall/issue counters; survive flush, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      issued_count <= '0;
    end else begin
      if (main_vld && !ex.out_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (main_vld && ex.out_ready && issued_count != 32'hFFFF_FFFF)
        issued_count <= issued_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage against a 2-deep queue reference model.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [10:0] opcode = '0;
  logic        alu_src = 1'b0;
  logic [63:0] read_data1 = '0;
  logic [63:0] read_data2 = '0;
  logic [63:0] imm = '0;
  logic [4:0]  rd_in = '0;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] issued_count;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t mq[$];

  alu_issue_stage_if #(.DATA_W(64), .REG_W(5)) ex_if ();

  alu_issue_stage #(.DATA_W(64), .REG_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .opcode     (opcode),
    .alu_src    (alu_src),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .imm        (imm),
    .rd_in      (rd_in),
    .ex         (ex_if.master)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .issued_count (issued_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the opcode table
  function automatic exp_t model_entry(logic [1:0] aop, logic [10:0] opc, logic src,
                                       logic [63:0] d1, logic [63:0] d2, logic [63:0] im,
                                       logic [4:0] rd);
    exp_t e;
    logic [9:0] top10;
    top10 = opc[10:1];
    e.op = 4'd0; e.ill = 1'b0;
    e.a = d1; e.b = src ? im : d2; e.rd = rd;
    if (aop == 2'd0) e.op = 4'd2;
    else if (aop == 2'd1) e.op = 4'd7;
    else if (aop == 2'd2) begin
      if      (opc == 11'b10001011000) e.op = 4'd2;
      else if (opc == 11'b11001011000) e.op = 4'd6;
      else if (opc == 11'b10001010000) e.op = 4'd0;
      else if (opc == 11'b10101010000) e.op = 4'd1;
      else if (opc == 11'b11101010000) e.op = 4'd12;
      else e.ill = 1'b1;
    end else begin
      if      (top10 == 10'b1001000100) e.op = 4'd2;
      else if (top10 == 10'b1101000100) e.op = 4'd6;
      else if (top10 == 10'b1001001000) e.op = 4'd0;
      else if (top10 == 10'b1011001000) e.op = 4'd1;
      else e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t dut_out();
    return {ex_if.alu_operation, ex_if.operand_a, ex_if.operand_b, ex_if.rd_out, ex_if.illegal};
  endfunction

  // Apply current inputs across one rising edge and advance the queue model; returns at negedge
  task automatic tick();
    bit   push, pop;
    exp_t e;
    push = in_valid && (mq.size() < 2) && !flush;
    pop  = ex_if.out_ready && (mq.size() > 0);
    e = model_entry(alu_op, opcode, alu_src, read_data1, read_data2, imm, rd_in);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic clear_pipe();
    in_valid = 1'b0; flush = 1'b1; ex_if.out_ready = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    in_valid = 1'b1; alu_op = 2'b10; opcode = 11'b10001011000;
    read_data1 = 64'h55; read_data2 = 64'h66; rd_in = 5'd3; ex_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ex_if.out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_hs: got vld/rdy %b%b want 01", ex_if.out_valid, in_ready);
    end
    n_cmp++;
    if (dut_out() !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", dut_out());
    end
    reset_n = 1'b1;
    mq.delete();
    tick();
    e = mq[0];
    n_cmp++;
    if (ex_if.out_valid !== 1'b1 || dut_out() !== e || mq.size() != 1) begin
      n_err++; $display("FAIL first_entry: got vld %b %h want 1 %h", ex_if.out_valid, dut_out(), e);
    end
  endtask

  task automatic test_rtype_sub();
    clear_pipe();
    in_valid = 1'b1; alu_op = 2'b10; opcode = 11'b11001011000; alu_src = 1'b0;
    read_data1 = 64'd10; read_data2 = 64'd3; imm = {$urandom, $urandom}; rd_in = 5'd7;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (ex_if.out_valid !== 1'b1 || ex_if.alu_operation !== 4'd6 || ex_if.operand_a !== 64'd10 ||
        ex_if.operand_b !== 64'd3 || ex_if.rd_out !== 5'd7 || ex_if.illegal !== 1'b0) begin
      n_err++; $display("FAIL rtype_sub: got %h want op 6 a 10 b 3 rd 7", dut_out());
    end
  endtask

  task automatic test_itype_add();
    clear_pipe();
    in_valid = 1'b1; alu_op = 2'b11; opcode = {10'b1001000100, 1'($urandom)}; alu_src = 1'b1;
    read_data1 = {$urandom, $urandom}; read_data2 = 64'h1234; imm = '1; rd_in = 5'd31;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (ex_if.alu_operation !== 4'd2 || ex_if.operand_b !== 64'hFFFF_FFFF_FFFF_FFFF ||
        ex_if.illegal !== 1'b0) begin
      n_err++; $display("FAIL itype_add: got op %0d b %h want op 2 b all ones",
                        ex_if.alu_operation, ex_if.operand_b);
    end
  endtask

  task automatic test_illegal_passb();
    clear_pipe();
    ex_if.out_ready = 1'b1;
    in_valid = 1'b1; alu_op = 2'b10; opcode = 11'd0; alu_src = 1'b0;
    tick();
    n_cmp++;
    if (ex_if.illegal !== 1'b1 || ex_if.alu_operation !== 4'd0 || ex_if.out_valid !== 1'b1) begin
      n_err++; $display("FAIL illegal: got ill %b op %0d want ill 1 op 0", ex_if.illegal, ex_if.alu_operation);
    end
    for (int k = 0; k < 3; k++) begin
      alu_op = 2'b01; opcode = 11'($urandom);
      tick();
      n_cmp++;
      if (ex_if.alu_operation !== 4'd7 || ex_if.illegal !== 1'b0) begin
        n_err++; $display("FAIL passb: got op %0d ill %b want op 7 ill 0", ex_if.alu_operation, ex_if.illegal);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx;
    int got_rd[$];
    clear_pipe();
    alu_op = 2'b00; alu_src = 1'b0;
    idx = 1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; rd_in = 5'(idx); read_data1 = 64'(idx * 100);
      if (in_ready) idx++;
      tick();
      if (c == 1) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b_ready_drop: got in_ready %b want 0", in_ready);
        end
      end
      n_cmp++;
      if (ex_if.rd_out !== 5'd1 || ex_if.out_valid !== 1'b1) begin
        n_err++; $display("FAIL b2b_hold: got rd %0d vld %b want rd 1 vld 1", ex_if.rd_out, ex_if.out_valid);
      end
    end
    ex_if.out_ready = 1'b1;
    for (int c = 0; c < 20 && got_rd.size() < 4; c++) begin
      if (ex_if.out_valid) got_rd.push_back(int'(ex_if.rd_out));
      if (idx <= 4) begin
        in_valid = 1'b1; rd_in = 5'(idx); read_data1 = 64'(idx * 100);
        if (in_ready) idx++;
      end else in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got_rd.size() != 4) begin
      n_err++; $display("FAIL b2b_count: got %0d entries want 4", got_rd.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (got_rd[k] != k + 1) begin
          n_err++; $display("FAIL b2b_order: slot %0d got rd %0d want %0d", k, got_rd[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    // Both slots full, flush with input offered
    clear_pipe();
    alu_op = 2'b00;
    for (int k = 1; k <= 2; k++) begin
      in_valid = 1'b1; rd_in = 5'(k); tick();
    end
    in_valid = 1'b1; rd_in = 5'd20; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({ex_if.out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_full: got vld/rdy %b%b want 01", ex_if.out_valid, in_ready);
    end
    ex_if.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (ex_if.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_ghost: got vld %b rd %0d want vld 0", ex_if.out_valid, ex_if.rd_out);
    end
    // One slot full, flush races a real input handshake
    ex_if.out_ready = 1'b0;
    in_valid = 1'b1; rd_in = 5'd4; tick();
    rd_in = 5'd21; flush = 1'b1; tick();
    flush = 1'b0; rd_in = 5'd9; tick();
    in_valid = 1'b0;
    n_cmp++;
    if (ex_if.out_valid !== 1'b1 || ex_if.rd_out !== 5'd9) begin
      n_err++; $display("FAIL flush_refill: got vld %b rd %0d want vld 1 rd 9", ex_if.out_valid, ex_if.rd_out);
    end
  endtask

  task automatic test_reset_midstall();
    clear_pipe();
    alu_op = 2'b01;
    for (int k = 1; k <= 2; k++) begin
      in_valid = 1'b1; rd_in = 5'(k); read_data2 = {$urandom, $urandom}; tick();
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ex_if.out_valid, in_ready} !== 2'b01 || dut_out() !== '0) begin
      n_err++; $display("FAIL reset_async: got vld/rdy %b%b data %h want 01 and 0",
                        ex_if.out_valid, in_ready, dut_out());
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_random();
    logic [10:0] opc_tab [0:8];
    int          sel;
    exp_t        e;
    opc_tab[0] = 11'b10001011000; opc_tab[1] = 11'b11001011000; opc_tab[2] = 11'b10001010000;
    opc_tab[3] = 11'b10101010000; opc_tab[4] = 11'b11101010000; opc_tab[5] = 11'b10010001000;
    opc_tab[6] = 11'b11010001001; opc_tab[7] = 11'b10010010000; opc_tab[8] = 11'b10110010001;
    clear_pipe();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      ex_if.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
      alu_op = 2'($urandom);
      sel = $urandom_range(0, 10);
      opcode = (sel <= 8) ? opc_tab[sel] : 11'($urandom);
      alu_src = 1'($urandom);
      read_data1 = {$urandom, $urandom}; read_data2 = {$urandom, $urandom};
      imm = {$urandom, $urandom}; rd_in = 5'($urandom);
      tick();
      n_cmp++;
      if (in_ready !== (mq.size() < 2) || ex_if.out_valid !== (mq.size() > 0)) begin
        n_err++; $display("FAIL rand_hs c%0d: got vld/rdy %b%b model depth %0d", c,
                          ex_if.out_valid, in_ready, mq.size());
      end else if (mq.size() > 0) begin
        e = mq[0];
        n_cmp++;
        if (dut_out() !== e) begin
          n_err++; $display("FAIL rand_data c%0d: got %h want %h", c, dut_out(), e);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    ex_if.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype_sub();
    test_itype_add();
    test_illegal_passb();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID-to-EX issue register for the LEGv8 pipeline; the producer side of the EX ALU interface.
- Decodes the 2-bit ALUOp and 11-bit opcode into the 4-bit ALU operation code.
- Registers the ALU operands A and B and the destination register, and presents them to EX with a valid/ready handshake.
- A 2-entry skid buffer gives a fully registered ready, so EX back-pressure never combinationally reaches decode.

Parameters:
- DATA_W, 64, operand width.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered entries (branch mispredict).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; registered.
- alu_op  in  2  control-unit ALUOp.
- opcode  in  11  instruction[31:21].
- alu_src  in  1  1 selects imm as B, 0 selects read_data2.
- read_data1  in  DATA_W  register-file port 1.
- read_data2  in  DATA_W  register-file port 2.
- imm  in  DATA_W  sign-extended immediate.
- rd_in  in  REG_W  destination register.
- out_valid  out  1  EX entry valid.
- out_ready  in  1  EX accepts.
- alu_operation  out  4  ALU code.
- operand_a  out  DATA_W  ALU A.
- operand_b  out  DATA_W  muxed ALU B.
- rd_out  out  REG_W  destination register.
- illegal  out  1  current out entry had an undecodable opcode.

Behaviour:
- Codes: AND=0, OR=1, ADD=2, SUB=6, PASSB=7, NOR=12.
- ALUOp 00 -> ADD (LDUR/STUR). ALUOp 01 -> PASSB (CBZ).
- ALUOp 10 (R-type):
  - 10001011000 -> ADD
  - 11001011000 -> SUB
  - 10001010000 -> AND
  - 10101010000 -> ORR
  - 11101010000 -> NOR
- ALUOp 11 (I-type, opcode[10:1]):
  - 1001000100 -> ADD
  - 1101000100 -> SUB
  - 1001001000 -> AND
  - 1011001000 -> OR
- Any other opcode -> code 0 with illegal=1. The entry still propagates; the hazard unit decides what to do with it.
- Decode and B-mux happen before the register: operand_b = alu_src ? imm : read_data2.
- Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
- Latency: an accepted instruction appears at the outputs on the next clk edge when the output slot is empty.
- Storage: main slot (drives outputs) plus one skid slot.
  - Output slot empty or draining: input loads the main slot directly.
  - Output slot stalled: input loads the skid slot.
  - When the main slot drains, the skid entry moves to it.
- in_ready = registered "skid empty". It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Ordering is strict FIFO; no entry is dropped or duplicated under any out_ready pattern.
- Full (both slots valid): in_ready=0. Any in_valid is ignored, with no capture.
- Simultaneous drain and fill with skid empty: the main slot reloads from input the same edge, giving 1 transfer/cycle sustained.
- flush=1 at an edge: both slots invalidate, out_valid=0 next cycle, in_ready=1 next cycle. An input handshake in the same cycle is discarded, since flush wins. An output handshake in the same cycle completes normally from EX's view.
- Reset (async assert, any time including mid-stall):
  - out_valid=0, in_ready=1, skid invalid.
  - alu_operation=0, operand_a=0, operand_b=0, rd_out=0, illegal=0.
- Outputs hold stable while out_valid & !out_ready.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: adds output ports stall_cycles (32) and issued_count (32).
  - stall_cycles increments each cycle out_valid & !out_ready.
  - issued_count increments on each output transfer.
  - Both saturate at 0xFFFFFFFF, clear on reset, and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_issue_pkg holds:
  - ALU code localparams (AND/OR/ADD/SUB/PASSB/NOR).
  - ALUOp encodings.
  - R/I opcode constants.
  - Entry struct {op, a, b, rd, illegal}.
- One combinational sub-module, alu_op_decode (alu_op, opcode -> code, illegal), shared with the hazard unit.

Test Plan:
- Reset with in_valid=1 held -> outputs all 0, out_valid=0; after reset_n rises, in_ready=1 and the first accepted entry appears 1 cycle later.
- ALUOp=10, opcode=11001011000, data1=10, data2=3, alu_src=0 -> alu_operation=6, operand_a=10, operand_b=3.
- ALUOp=11, opcode=1001000100x, imm=0xFFFFFFFFFFFFFFFF, alu_src=1 -> code 2, operand_b=all ones.
- Back-to-back issue of 4 entries with out_ready=0 for 3 cycles:
  - in_ready falls after 2 accepted.
  - Outputs hold entry 1.
  - On release, entries drain in order 1-4 with no loss.
- flush asserted in the same cycle as an input handshake, with both slots full -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- ALUOp=10, opcode=00000000000 -> illegal=1, alu_operation=0; ALUOp=01 -> code 7 regardless of opcode.
